// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM host-port arbiter slice.
package sdram_pkg;

   // Host address layout {ba, row, col}
   localparam int unsigned BA_W  = 2;
   localparam int unsigned ROW_W = 13;
   localparam int unsigned COL_W = 9;

   localparam logic HRW_WRITE = 1'b1;
   localparam logic HRW_READ  = 1'b0;

   typedef enum logic [1:0] {IDLE, ISSUE, GUARD} arb_state_t;

   // Round-robin candidate k positions after ptr, wrapping modulo n.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned k,
                                           input int unsigned n);
      return (ptr + k) % n;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-side and controller-side bus of the SDRAM host-port arbiter.
interface sdram_port_arbiter_if #(
   parameter int unsigned NPORTS = 4,
   parameter int unsigned AWIDTH = 24,
   parameter int unsigned DWIDTH = 16
);
   logic [NPORTS-1:0]        req_valid;
   logic [NPORTS-1:0]        req_rw;
   logic [NPORTS*AWIDTH-1:0] req_addr;
   logic [NPORTS*DWIDTH-1:0] req_wdata;
   logic [NPORTS-1:0]        req_ack;
   logic [NPORTS-1:0]        rsp_valid;
   logic [DWIDTH-1:0]        rsp_data;
   logic                     ctrl_busy;
   logic [AWIDTH-1:0]        ctrl_haddr;
   logic                     ctrl_hrw;
   logic                     ctrl_hrw_req;
   logic [DWIDTH-1:0]        ctrl_hdata_in;
   logic                     ctrl_hdata_out_valid;
   logic [DWIDTH-1:0]        ctrl_hdata_out;

   // Arbiter view
   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, ctrl_busy, ctrl_hdata_out_valid,
             ctrl_hdata_out,
      output req_ack, rsp_valid, rsp_data, ctrl_haddr, ctrl_hrw, ctrl_hrw_req, ctrl_hdata_in
   );

   // Clients plus controller view
   modport master (
      output req_valid, req_rw, req_addr, req_wdata, ctrl_busy, ctrl_hdata_out_valid,
             ctrl_hdata_out,
      input  req_ack, rsp_valid, rsp_data, ctrl_haddr, ctrl_hrw, ctrl_hrw_req, ctrl_hdata_in
   );

endinterface

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO of requester tags for reads in flight, oldest at the head.
module sdram_tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Extra MSB on each pointer separates full from empty
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller host port between NPORTS clients,
// routing read data back to the issuing client in order.
module sdram_port_arbiter
   import sdram_pkg::*;
#(
   parameter int unsigned NPORTS    = 4,
   parameter int unsigned AWIDTH    = 24,
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   sdram_port_arbiter_if.slave          bus,
   output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
   output logic                         err_orphan
);
   localparam int unsigned PW = $clog2(NPORTS);
   localparam logic [NPORTS-1:0] ONEHOT0 = 1;

   arb_state_t          state_q;
   logic [PW-1:0]       rr_ptr_q;
   logic [NPORTS-1:0]   req_ack_q;
   logic [AWIDTH-1:0]   haddr_q;
   logic                hrw_q;
   logic                hrw_req_q;
   logic [DWIDTH-1:0]   hdata_in_q;
   logic [NPORTS-1:0]   rsp_valid_q;
   logic [DWIDTH-1:0]   rsp_data_q;
   logic                err_orphan_q;

   logic [NPORTS-1:0]   eligible;
   logic                any_elig;
   logic [PW-1:0]       winner;
   logic [AWIDTH-1:0]   win_addr;
   logic [DWIDTH-1:0]   win_data;
   logic                win_rw;

   logic                tag_full;
   logic                tag_empty;
   logic [PW-1:0]       tag_dout;
   logic                push_req;
   logic                pop_req;
   logic                fifo_push;
   logic                fifo_pop;
   logic                orphan;
   logic [PW-1:0]       rsp_tag;

   always_comb begin
      eligible = '0;
      any_elig = 1'b0;
      winner   = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         eligible[i] = bus.req_valid[i] && (bus.req_rw[i] == HRW_WRITE || !tag_full);
      end
      for (int unsigned k = 1; k <= NPORTS; k++) begin
         logic [PW-1:0] idx;
         idx = PW'(rr_next(32'(rr_ptr_q), k, NPORTS));
         if (!any_elig && eligible[idx]) begin
            any_elig = 1'b1;
            winner   = idx;
         end
      end
   end

   always_comb begin
      win_addr = '0;
      win_data = '0;
      win_rw   = HRW_READ;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         if (PW'(i) == winner) begin
            win_addr = bus.req_addr[i*AWIDTH +: AWIDTH];
            win_data = bus.req_wdata[i*DWIDTH +: DWIDTH];
            win_rw   = bus.req_rw[i];
         end
      end
   end

   // Grant in IDLE, strobe the controller in ISSUE, then one quiet GUARD cycle
   // so the controller's registered busy is visible before the next grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= PW'(NPORTS - 1);
         req_ack_q  <= '0;
         haddr_q    <= '0;
         hrw_q      <= 1'b0;
         hrw_req_q  <= 1'b0;
         hdata_in_q <= '0;
      end else begin
         req_ack_q <= '0;
         hrw_req_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!bus.ctrl_busy && any_elig) begin
                  haddr_q    <= win_addr;
                  hrw_q      <= win_rw;
                  hdata_in_q <= win_data;
                  rr_ptr_q   <= winner;
                  req_ack_q  <= ONEHOT0 << winner;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               hrw_req_q <= 1'b1;
               state_q   <= GUARD;
            end
            GUARD: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // rr_ptr_q still names the granted port while in ISSUE
   assign push_req = (state_q == ISSUE) && (hrw_q == HRW_READ);
   assign pop_req  = bus.ctrl_hdata_out_valid;
   assign orphan   = pop_req && tag_empty && !push_req;
   // Data returning as its tag is pushed into an empty FIFO bypasses it
   assign rsp_tag   = tag_empty ? rr_ptr_q : tag_dout;
   assign fifo_push = push_req && !(tag_empty && pop_req);
   assign fifo_pop  = pop_req && !tag_empty;

   sdram_tag_fifo #(
      .WIDTH (PW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rr_ptr_q),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty),
      .count (rd_outstanding)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         rsp_valid_q <= (pop_req && !orphan) ? (ONEHOT0 << rsp_tag) : '0;
         if (pop_req && !orphan) rsp_data_q <= bus.ctrl_hdata_out;
         if (orphan) err_orphan_q <= 1'b1;
      end
   end

   assign bus.req_ack       = req_ack_q;
   assign bus.ctrl_haddr    = haddr_q;
   assign bus.ctrl_hrw      = hrw_q;
   assign bus.ctrl_hrw_req  = hrw_req_q;
   assign bus.ctrl_hdata_in = hdata_in_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_data      = rsp_data_q;
   assign err_orphan        = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed client commands and read returns.
module tb_sdram_port_arbiter;
   localparam int unsigned NP = 4;
   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned TD = 4;
   localparam int unsigned CW = $clog2(TD) + 1;

   typedef struct packed {logic rw; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
   typedef struct packed {logic [1:0] port; cmd_t cmd;} exp_cmd_t;
   typedef struct packed {logic [NP-1:0] onehot; logic [DW-1:0] data;} exp_rsp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] rd_outstanding;
   logic          err_orphan;

   sdram_port_arbiter_if #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW)) bus ();

   sdram_port_arbiter #(
      .NPORTS    (NP),
      .AWIDTH    (AW),
      .DWIDTH    (DW),
      .TAG_DEPTH (TD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .rd_outstanding (rd_outstanding),
      .err_orphan     (err_orphan)
   );

   always #5 clk = ~clk;

   cmd_t     port_q [NP][$];
   exp_cmd_t exp_cmd [$];
   exp_rsp_t exp_rsp [$];
   int       issue_log [$];
   int cyc = 0, n_cmp = 0, n_err = 0, n_acks = 0, n_issues = 0, n_rsps = 0;
   int last_ack_cyc = 0, last_ack_port = 0, last_issue_cyc = -100, ret_cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send(input int p, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      cmd_t c;
      c.rw = rw; c.addr = a; c.data = d;
      port_q[p].push_back(c);
   endtask

   task automatic exp_c(input int p, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      exp_cmd_t e;
      e.port = 2'(p); e.cmd.rw = rw; e.cmd.addr = a; e.cmd.data = d;
      exp_cmd.push_back(e);
   endtask

   task automatic exp_r(input logic [NP-1:0] oh, input logic [DW-1:0] d);
      exp_rsp_t r;
      r.onehot = oh; r.data = d;
      exp_rsp.push_back(r);
   endtask

   task automatic ret(input logic [DW-1:0] d);
      @(posedge clk); #1;
      bus.ctrl_hdata_out_valid = 1'b1;
      bus.ctrl_hdata_out       = d;
      ret_cyc                  = cyc;
      @(posedge clk); #1;
      bus.ctrl_hdata_out_valid = 1'b0;
   endtask

   task automatic wait_issues(input string name, input int target);
      int budget = 60;
      while (n_issues < target && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check(name, n_issues, target);
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      for (int p = 0; p < NP; p++) port_q[p].delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Client FIFOs: pop on ack, present the head command
   initial forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
         if (bus.req_ack[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
         if (port_q[p].size() > 0) begin
            bus.req_valid[p]             = 1'b1;
            bus.req_rw[p]                = port_q[p][0].rw;
            bus.req_addr[p*AW +: AW]     = port_q[p][0].addr;
            bus.req_wdata[p*DW +: DW]    = port_q[p][0].data;
         end else begin
            bus.req_valid[p] = 1'b0;
         end
      end
   end

   // Monitor: compare DUT outputs against scoreboard queues
   initial forever begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
         check("ack_onehot", $countones(bus.req_ack), 1);
         for (int p = 0; p < NP; p++) if (bus.req_ack[p]) last_ack_port = p;
         last_ack_cyc = cyc;
         n_acks++;
      end
      if (bus.ctrl_hrw_req) begin
         check("ack_to_issue", cyc - last_ack_cyc, 1);
         check("issue_spacing_ge3", 32'(cyc - last_issue_cyc >= 3), 1);
         check("issue_has_expected", 32'(exp_cmd.size() != 0), 1);
         if (exp_cmd.size() != 0) begin
            exp_cmd_t e;
            e = exp_cmd.pop_front();
            check("issue_port", last_ack_port, e.port);
            check("issue_hrw", bus.ctrl_hrw, e.cmd.rw);
            check("issue_haddr", bus.ctrl_haddr, e.cmd.addr);
            check("issue_hdata_in", bus.ctrl_hdata_in, e.cmd.data);
         end
         last_issue_cyc = cyc;
         issue_log.push_back(cyc);
         n_issues++;
      end
      if (bus.rsp_valid != '0) begin
         n_rsps++;
         check("rsp_has_expected", 32'(exp_rsp.size() != 0), 1);
         check("rsp_latency", cyc - ret_cyc, 1);
         if (exp_rsp.size() != 0) begin
            exp_rsp_t r;
            r = exp_rsp.pop_front();
            check("rsp_valid", bus.rsp_valid, r.onehot);
            check("rsp_data", bus.rsp_data, r.data);
         end
      end
   end

   initial begin
      int t0, base, acks0, rsps0;
      bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.ctrl_busy = 1'b0; bus.ctrl_hdata_out_valid = 1'b0; bus.ctrl_hdata_out = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ack", bus.req_ack, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_hrw_req", bus.ctrl_hrw_req, 0);
      check("rst_haddr", bus.ctrl_haddr, 0);
      check("rst_hdata_in", bus.ctrl_hdata_in, 0);
      check("rst_rd_outstanding", rd_outstanding, 0);
      check("rst_err_orphan", err_orphan, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single write
      @(negedge clk);
      send(0, 1'b1, 24'h00AA55, 16'hBEEF);
      exp_c(0, 1'b1, 24'h00AA55, 16'hBEEF);
      t0 = cyc;
      wait_issues("t1_issue", 1);
      check("t1_ack_cycle", last_ack_cyc, t0 + 2);
      check("t1_issue_cycle", last_issue_cyc, t0 + 3);
      check("t1_rd_outstanding", rd_outstanding, 0);

      // Round-robin fairness from reset pointer
      reset_dut();
      @(negedge clk);
      base = n_issues;
      issue_log.delete();
      send(0, 1'b1, 24'h000010, 16'hA010);
      send(0, 1'b1, 24'h000011, 16'hA011);
      for (int p = 1; p < NP; p++) send(p, 1'b1, 24'(32'h20 + p), 16'(32'hA020 + p));
      exp_c(0, 1'b1, 24'h000010, 16'hA010);
      for (int p = 1; p < NP; p++) exp_c(p, 1'b1, 24'(32'h20 + p), 16'(32'hA020 + p));
      exp_c(0, 1'b1, 24'h000011, 16'hA011);
      wait_issues("t2_issues", base + 5);
      for (int i = 1; i < 5; i++) check("t2_gap", issue_log[i] - issue_log[i-1], 3);

      // Read routing
      reset_dut();
      @(negedge clk);
      base = n_issues;
      send(2, 1'b0, 24'h000200, 16'h0002);
      exp_c(2, 1'b0, 24'h000200, 16'h0002);
      wait_issues("t3_issue_p2", base + 1);
      @(negedge clk);
      send(1, 1'b0, 24'h000100, 16'h0001);
      exp_c(1, 1'b0, 24'h000100, 16'h0001);
      wait_issues("t3_issue_p1", base + 2);
      check("t3_rd_outstanding_2", rd_outstanding, 2);
      exp_r(4'b0100, 16'h1111);
      exp_r(4'b0010, 16'h2222);
      ret(16'h1111);
      ret(16'h2222);
      repeat (2) @(posedge clk);
      check("t3_rd_outstanding_0", rd_outstanding, 0);

      // Tag FIFO full
      reset_dut();
      @(negedge clk);
      base = n_issues;
      for (int p = 0; p < NP; p++) begin
         send(p, 1'b0, 24'(32'h400 + p), 16'(32'h40 + p));
         exp_c(p, 1'b0, 24'(32'h400 + p), 16'(32'h40 + p));
      end
      wait_issues("t4_fill", base + 4);
      check("t4_full_count", rd_outstanding, 4);
      @(negedge clk);
      send(0, 1'b0, 24'h000500, 16'h0050);
      send(3, 1'b1, 24'h000503, 16'h5503);
      exp_c(3, 1'b1, 24'h000503, 16'h5503);
      exp_c(0, 1'b0, 24'h000500, 16'h0050);
      wait_issues("t4_write_wins", base + 5);
      repeat (12) @(posedge clk);
      check("t4_read_waits", n_issues, base + 5);
      exp_r(4'b0001, 16'h3001);
      ret(16'h3001);
      wait_issues("t4_read_after_pop", base + 6);
      check("t4_count_after_refill", rd_outstanding, 4);
      exp_r(4'b0010, 16'h3002);
      exp_r(4'b0100, 16'h3003);
      exp_r(4'b1000, 16'h3004);
      exp_r(4'b0001, 16'h3005);
      ret(16'h3002); ret(16'h3003); ret(16'h3004); ret(16'h3005);
      repeat (2) @(posedge clk);
      check("t4_drained", rd_outstanding, 0);

      // Busy stall
      reset_dut();
      @(posedge clk); #1 bus.ctrl_busy = 1'b1;
      @(negedge clk);
      base  = n_issues;
      acks0 = n_acks;
      send(1, 1'b1, 24'h000601, 16'h6601);
      send(2, 1'b1, 24'h000602, 16'h6602);
      exp_c(1, 1'b1, 24'h000601, 16'h6601);
      exp_c(2, 1'b1, 24'h000602, 16'h6602);
      repeat (20) @(posedge clk);
      check("t5_no_ack_busy", n_acks, acks0);
      check("t5_no_issue_busy", n_issues, base);
      @(posedge clk); #1 bus.ctrl_busy = 1'b0;
      t0 = cyc;
      wait_issues("t5_first", base + 1);
      check("t5_first_ack_cycle", last_ack_cyc, t0 + 1);
      wait_issues("t5_second", base + 2);

      // Orphan after reset with reads in flight
      reset_dut();
      @(negedge clk);
      base = n_issues;
      send(0, 1'b0, 24'h000700, 16'h0070);
      send(1, 1'b0, 24'h000701, 16'h0071);
      exp_c(0, 1'b0, 24'h000700, 16'h0070);
      exp_c(1, 1'b0, 24'h000701, 16'h0071);
      wait_issues("t6_issues", base + 2);
      check("t6_outstanding_2", rd_outstanding, 2);
      reset_dut();
      check("t6_rst_outstanding", rd_outstanding, 0);
      check("t6_rst_err_clear", err_orphan, 0);
      rsps0 = n_rsps;
      ret(16'h7777);
      repeat (3) @(posedge clk);
      check("t6_no_rsp", n_rsps, rsps0);
      check("t6_err_orphan", err_orphan, 1);
      check("t6_outstanding_0", rd_outstanding, 0);
      repeat (5) @(posedge clk);
      check("t6_err_sticky", err_orphan, 1);

      check("end_exp_cmd_empty", exp_cmd.size(), 0);
      check("end_exp_rsp_empty", exp_rsp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
